// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bundle of the register file with RAW scoreboard.
// The master side (core pipeline) drives reads, writebacks and issues; the slave is the register file.
interface regfile_scoreboard_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            re;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] datars1;
    logic [XLEN-1:0] datars2;
    logic            we;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] datard;
    logic            issue;
    logic [AW-1:0]   issue_rd;
    logic            clear;
    logic            hazard;
    logic [AW:0]     pending_cnt;

    modport master (
        output re, rs1, rs2, we, rd, datard, issue, issue_rd, clear,
        input  datars1, datars2, hazard, pending_cnt
    );

    modport slave (
        input  re, rs1, rs2, we, rd, datard, issue, issue_rd, clear,
        output datars1, datars2, hazard, pending_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// 2R/1W register file with optional x0 hardwiring and write-to-read bypass,
// plus a per-register pending-write scoreboard that flags RAW hazards to decode.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    regfile_scoreboard_if.slave  rr
);
    localparam int NREG = 2 ** AW;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic [AW:0]     cnt_q;
    logic [AW:0]     cnt_d;
    logic            wr_ok;
    logic            issue_ok;
    logic            cnt_inc;
    logic            cnt_dec;

    function automatic logic [XLEN-1:0] read_mux(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] stored,
        input logic            we,
        input logic [AW-1:0]   rd,
        input logic [XLEN-1:0] wdata
    );
        if (ZERO_REG != 0 && addr == '0) begin
            return '0;
        end
        if (BYPASS != 0 && we && rd == addr) begin
            return wdata;
        end
        return stored;
    endfunction

    function automatic logic hazard_on(
        input logic [AW-1:0] addr,
        input logic          pend,
        input logic          we,
        input logic [AW-1:0] rd
    );
        logic zero_masked;
        logic bypass_masked;
        zero_masked   = (ZERO_REG != 0) && (addr == '0);
        bypass_masked = (BYPASS != 0) && we && (rd == addr);
        return pend && !zero_masked && !bypass_masked;
    endfunction

    assign wr_ok    = rr.we && !(ZERO_REG != 0 && rr.rd == '0);
    assign issue_ok = rr.issue && !(ZERO_REG != 0 && rr.issue_rd == '0);

    always_comb begin
        rr.datars1 = read_mux(rr.rs1, regs[rr.rs1], rr.we, rr.rd, rr.datard);
        rr.datars2 = read_mux(rr.rs2, regs[rr.rs2], rr.we, rr.rd, rr.datard);
        rr.hazard  = rr.re && (hazard_on(rr.rs1, pending_q[rr.rs1], rr.we, rr.rd) ||
                               hazard_on(rr.rs2, pending_q[rr.rs2], rr.we, rr.rd));
    end

    // Writeback clears before issue sets, so a same-register pair leaves the bit set.
    always_comb begin
        pending_d = pending_q;
        cnt_d     = cnt_q;
        cnt_inc   = 1'b0;
        cnt_dec   = 1'b0;
        if (rr.clear) begin
            pending_d = '0;
            cnt_d     = '0;
        end else begin
            if (rr.we) begin
                pending_d[rr.rd] = 1'b0;
            end
            if (issue_ok) begin
                pending_d[rr.issue_rd] = 1'b1;
            end
            cnt_inc = issue_ok && !pending_q[rr.issue_rd];
            cnt_dec = rr.we && pending_q[rr.rd] && !(issue_ok && rr.issue_rd == rr.rd);
            cnt_d   = cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[rr.rd] <= rr.datard;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rr.pending_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a reference model pushes expected outputs to a queue
// per cycle; they are popped and compared against a BYPASS=1 and a BYPASS=0 instance.
module tb_regfile_scoreboard;
    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    regfile_scoreboard_if #(.XLEN(32), .AW(5)) rr ();
    regfile_scoreboard_if #(.XLEN(32), .AW(5)) rr_nb ();

    regfile_scoreboard #(.XLEN(32), .AW(5), .BYPASS(1), .ZERO_REG(1)) u_dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .rr(rr.slave));
    regfile_scoreboard #(.XLEN(32), .AW(5), .BYPASS(0), .ZERO_REG(1)) u_dut_nb (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .rr(rr_nb.slave));

    assign rr_nb.re       = rr.re;
    assign rr_nb.rs1      = rr.rs1;
    assign rr_nb.rs2      = rr.rs2;
    assign rr_nb.we       = rr.we;
    assign rr_nb.rd       = rr.rd;
    assign rr_nb.datard   = rr.datard;
    assign rr_nb.issue    = rr.issue;
    assign rr_nb.issue_rd = rr.issue_rd;
    assign rr_nb.clear    = rr.clear;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_regs[32];
    logic        m_pend[32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, obs, e.exp);
        end
    endtask

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += m_pend[i] ? 1 : 0;
        return c;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] rs, input logic byp,
                                             input logic we, input logic [4:0] rd,
                                             input logic [31:0] d);
        if (rs == 5'd0) return 32'd0;
        if (byp && we && rd == rs) return d;
        return m_regs[rs];
    endfunction

    function automatic logic exp_hz1(input logic [4:0] rs, input logic byp,
                                     input logic we, input logic [4:0] rd);
        return m_pend[rs] && rs != 5'd0 && !(byp && we && rd == rs);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic idle();
        rr.re = 1'b0; rr.rs1 = 5'd0; rr.rs2 = 5'd0;
        rr.we = 1'b0; rr.rd = 5'd0; rr.datard = 32'd0;
        rr.issue = 1'b0; rr.issue_rd = 5'd0; rr.clear = 1'b0;
    endtask

    task automatic cyc(input logic re, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic iss, input logic [4:0] ird, input logic clr);
        logic hz;
        logic hz_nb;
        @(negedge clk_i);
        rr.re = re; rr.rs1 = rs1; rr.rs2 = rs2;
        rr.we = we; rr.rd = rd; rr.datard = d;
        rr.issue = iss; rr.issue_rd = ird; rr.clear = clr;
        #1;
        hz    = re && (exp_hz1(rs1, 1'b1, we, rd) || exp_hz1(rs2, 1'b1, we, rd));
        hz_nb = re && (exp_hz1(rs1, 1'b0, we, rd) || exp_hz1(rs2, 1'b0, we, rd));
        push("rd1",    exp_read(rs1, 1'b1, we, rd, d));
        push("rd2",    exp_read(rs2, 1'b1, we, rd, d));
        push("hazard", {31'd0, hz});
        push("rd1_nb", exp_read(rs1, 1'b0, we, rd, d));
        push("hz_nb",  {31'd0, hz_nb});
        pop_check(rr.datars1);
        pop_check(rr.datars2);
        pop_check({31'd0, rr.hazard});
        pop_check(rr_nb.datars1);
        pop_check({31'd0, rr_nb.hazard});
        @(posedge clk_i);
        if (we && rd != 5'd0) m_regs[rd] = d;
        if (clr) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end else begin
            if (we) m_pend[rd] = 1'b0;
            if (iss && ird != 5'd0) m_pend[ird] = 1'b1;
        end
        #1;
        push("cnt",    32'(model_cnt()));
        push("cnt_nb", 32'(model_cnt()));
        pop_check(32'(rr.pending_cnt));
        pop_check(32'(rr_nb.pending_cnt));
    endtask

    initial begin
        idle();
        model_reset();
        rst_n_i = 1'b0;
        #1;
        rr.re = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rr.rs1 = 5'(i);
            rr.rs2 = 5'(31 - i);
            #1;
            check("rst_rd1", rr.datars1, 32'd0);
            check("rst_rd2", rr.datars2, 32'd0);
            check("rst_hazard", {31'd0, rr.hazard}, 32'd0);
        end
        check("rst_cnt", 32'(rr.pending_cnt), 32'd0);
        idle();
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        // Plain write/read and x0 hardwiring
        cyc(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        cyc(1, 5, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 32'h00001234, 0, 0, 0);
        cyc(1, 5, 0, 0, 0, 0, 0, 0, 0);
        // Same-cycle bypass on x7 (BYPASS=0 instance must show the old value)
        cyc(0, 0, 0, 1, 7, 32'h11111111, 0, 0, 0);
        cyc(1, 7, 7, 1, 7, 32'hA5A5A5A5, 0, 0, 0);
        cyc(1, 7, 0, 0, 0, 0, 0, 0, 0);
        // RAW hazard on x3 and its release by writeback
        cyc(0, 0, 0, 0, 0, 0, 1, 3, 0);
        cyc(1, 3, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 3, 0, 1, 3, 32'h33333333, 0, 0, 0);
        cyc(1, 3, 0, 0, 0, 0, 0, 0, 0);
        // Issue and writeback to the same pending register; issue to x0
        cyc(0, 0, 0, 0, 0, 0, 1, 4, 0);
        cyc(1, 0, 4, 1, 4, 32'h44444444, 1, 4, 0);
        cyc(1, 4, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 4, 0);
        // Writeback to a non-pending register leaves the count alone
        cyc(0, 0, 0, 1, 12, 32'hC0C0C0C0, 0, 0, 0);
        // Flush with concurrent issue and writeback
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 2, 0);
        cyc(1, 1, 2, 0, 0, 0, 1, 3, 0);
        cyc(0, 0, 0, 1, 10, 32'h0BADF00D, 1, 9, 1);
        cyc(1, 9, 10, 0, 0, 0, 0, 0, 0);

        // Randomised traffic on a small register window to hit hazards often
        for (int n = 0; n < 300; n++) begin
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                ($urandom_range(0, 19) == 0));
        end

        // Asynchronous reset between clock edges with pending work outstanding
        cyc(0, 0, 0, 1, 6, 32'h66666666, 1, 6, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 5, 0);
        @(negedge clk_i);
        idle();
        rr.re = 1'b1; rr.rs1 = 5'd6; rr.rs2 = 5'd5;
        #2;
        rst_n_i = 1'b0;
        #1;
        model_reset();
        check("async_rd1", rr.datars1, 32'd0);
        check("async_hazard", {31'd0, rr.hazard}, 32'd0);
        check("async_cnt", 32'(rr.pending_cnt), 32'd0);
        check("async_cnt_nb", 32'(rr_nb.pending_cnt), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        idle();
        cyc(1, 5, 6, 1, 8, 32'h88888888, 1, 8, 0);
        cyc(1, 8, 6, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
